// File: rtl/ble_tx_fifo_sequencer.sv
// Write-side sequencer for the BLE PHY TX async FIFO: clears the FIFO, streams
// ceil(len/32) source words into it, waits for the PHY side to drain, then reports.
module ble_tx_fifo_sequencer #(
   parameter int DATA      = 32,
   parameter int DRAIN_TMO = 4096
) (
   input  logic            W_CLK,
   input  logic            RST,
   input  logic            start,
   input  logic            abort,
   input  logic [16:0]     data_size,
   input  logic            src_valid,
   input  logic [DATA-1:0] src_data,
   output logic            src_ready,
   input  logic            fifo_full,
   input  logic            fifo_empty,
   output logic            fifo_w_inc,
   output logic [DATA-1:0] fifo_w_data,
   output logic            tx_irq,
   output logic            busy,
   output logic            done,
   output logic            error,
   output logic [11:0]     words_left,
   output logic [2:0]      state_dbg
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam int TW = (DRAIN_TMO > 1) ? $clog2(DRAIN_TMO) : 1;

   logic [2:0]    state, state_nxt;
   logic [11:0]   words_q;
   logic          tx_irq_q, error_q;
   logic          empty_m, empty_s;
   logic [TW-1:0] drain_cnt;
   logic          drain_seen, empty_run;
   logic [16:0]   ds_clamp;
   logic [11:0]   words_new;
   logic          abort_eff, accept, zero_job, transfer, drained, timeout;

   // 4096 words would wrap to 0 in 12 bits, so lengths are clamped to 4095 words.
   assign ds_clamp  = (data_size > 17'd131040) ? 17'd131040 : data_size;
   assign words_new = 12'((ds_clamp + 17'd31) >> 5);

   assign abort_eff = abort & (state != S_IDLE);
   assign accept    = (state == S_IDLE) & start & ~abort & (data_size != 17'd0);
   assign zero_job  = (state == S_IDLE) & start & ~abort & (data_size == 17'd0);

   // Source handshake: a word moves on any rising edge where src_valid and
   // src_ready are both high; src_valid must not depend on src_ready, and the
   // word is forwarded to the FIFO in that same cycle with no buffering.
   assign src_ready   = (state == S_LOAD) & ~fifo_full & (words_q != 12'd0);
   assign transfer    = src_valid & src_ready;
   assign fifo_w_inc  = transfer;
   assign fifo_w_data = src_data;

   // The first DRAIN sample is skipped: the synchroniser may still show a stale empty.
   assign drained = (state == S_DRAIN) & drain_seen & empty_s & empty_run;
   assign timeout = (DRAIN_TMO != 0) && (state == S_DRAIN) &&
                    (drain_cnt == TW'(DRAIN_TMO - 1)) && !drained;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_CLEAR;
         S_CLEAR: state_nxt = S_LOAD;
         S_LOAD:  if (transfer && words_q == 12'd1) state_nxt = S_DRAIN;
         S_DRAIN: begin
            if (drained)      state_nxt = S_DONE;
            else if (timeout) state_nxt = S_IDLE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (abort_eff) state_nxt = S_IDLE;
   end

   always_ff @(posedge W_CLK) begin
      if (RST) begin
         state      <= S_IDLE;
         words_q    <= 12'd0;
         tx_irq_q   <= 1'b0;
         error_q    <= 1'b0;
         empty_m    <= 1'b1;
         empty_s    <= 1'b1;
         drain_cnt  <= '0;
         drain_seen <= 1'b0;
         empty_run  <= 1'b0;
      end else begin
         state    <= state_nxt;
         empty_m  <= fifo_empty;
         empty_s  <= empty_m;
         tx_irq_q <= (state_nxt == S_CLEAR) | abort_eff | (timeout & ~abort_eff);
         error_q  <= zero_job | (timeout & ~abort_eff);

         if (abort_eff)     words_q <= 12'd0;
         else if (accept)   words_q <= words_new;
         else if (transfer) words_q <= words_q - 12'd1;

         if (state != S_DRAIN) begin
            drain_cnt  <= '0;
            drain_seen <= 1'b0;
            empty_run  <= 1'b0;
         end else begin
            drain_cnt  <= drain_cnt + TW'(1);
            drain_seen <= 1'b1;
            empty_run  <= drain_seen & empty_s;
         end
      end
   end

   assign tx_irq     = tx_irq_q;
   assign error      = error_q;
   assign done       = (state == S_DONE);
   assign busy       = (state != S_IDLE);
   assign words_left = words_q;
   assign state_dbg  = state;

endmodule

// File: tb/tb_ble_tx_fifo_sequencer.sv
// Self-checking bench for ble_tx_fifo_sequencer: scoreboarded FIFO writes,
// pulse counting and directed job scenarios.
module tb_ble_tx_fifo_sequencer;

   logic        W_CLK = 1'b0;
   logic        RST, start, abort, src_valid, fifo_full, fifo_empty;
   logic [16:0] data_size;
   logic [31:0] src_data;
   logic        src_ready, fifo_w_inc, tx_irq, busy, done, error;
   logic [31:0] fifo_w_data;
   logic [11:0] words_left;
   logic [2:0]  state_dbg;

   logic [31:0] exp_q[$];
   logic [31:0] src_buf[$];
   int n_checks = 0;
   int n_fail   = 0;
   int wr_cnt = 0, irq_cnt = 0, done_cnt = 0, err_cnt = 0;
   int wr0;

   ble_tx_fifo_sequencer #(.DATA(32), .DRAIN_TMO(16)) dut (
      .W_CLK(W_CLK), .RST(RST), .start(start), .abort(abort), .data_size(data_size),
      .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_w_inc(fifo_w_inc),
      .fifo_w_data(fifo_w_data), .tx_irq(tx_irq), .busy(busy), .done(done),
      .error(error), .words_left(words_left), .state_dbg(state_dbg)
   );

   always #5 W_CLK = ~W_CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Monitor: scoreboard FIFO writes and count output pulses mid-cycle.
   always @(negedge W_CLK) begin
      if (!RST) begin
         if (tx_irq) irq_cnt++;
         if (done)   done_cnt++;
         if (error)  err_cnt++;
         if (fifo_w_inc) begin
            wr_cnt++;
            if (exp_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
            else chk("wr_data", fifo_w_data, exp_q.pop_front());
            if (src_buf.size() != 0) void'(src_buf.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge W_CLK);
      #1;
      src_valid = (src_buf.size() != 0);
      src_data  = src_valid ? src_buf[0] : 32'd0;
   endtask

   task automatic load_words(input int n_src, input int n_exp);
      for (int i = 0; i < n_src; i++) begin
         logic [31:0] w;
         w = $urandom;
         src_buf.push_back(w);
         if (i < n_exp) exp_q.push_back(w);
      end
   endtask

   task automatic clr_counts();
      irq_cnt = 0; done_cnt = 0; err_cnt = 0; wr0 = wr_cnt;
   endtask

   task automatic pulse_start(input int size);
      start = 1'b1;
      data_size = 17'(size);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      if (busy) chk({tag, "_idle_timeout"}, 32'd1, 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, dcyc;
      RST = 1'b1; start = 1'b0; abort = 1'b0; data_size = '0;
      src_valid = 1'b0; src_data = '0; fifo_full = 1'b0; fifo_empty = 1'b1;
      repeat (3) tick();
      chk("rst_src_ready", src_ready, 0);
      chk("rst_w_inc", fifo_w_inc, 0);
      chk("rst_tx_irq", tx_irq, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_words_left", words_left, 0);
      RST = 1'b0;
      tick();

      // 96 bits -> 3 words
      clr_counts();
      load_words(3, 3);
      pulse_start(96);
      chk("j96_clear_irq", tx_irq, 1);
      chk("j96_busy", busy, 1);
      chk("j96_words_left", words_left, 3);
      chk("j96_clear_ready", src_ready, 0);
      tick();
      chk("j96_irq_one_cycle", tx_irq, 0);
      chk("j96_load_ready", src_ready, 1);
      wait_idle("j96", 100);
      chk("j96_writes", wr_cnt - wr0, 3);
      chk("j96_irq_cnt", irq_cnt, 1);
      chk("j96_done_cnt", done_cnt, 1);
      chk("j96_err_cnt", err_cnt, 0);
      chk("j96_exp_left", exp_q.size(), 0);

      // 33 bits -> exactly 2 words even with a third one offered
      clr_counts();
      load_words(3, 2);
      pulse_start(33);
      chk("j33_words_left", words_left, 2);
      wait_idle("j33", 100);
      chk("j33_writes", wr_cnt - wr0, 2);
      chk("j33_src_left", src_buf.size(), 1);
      chk("j33_done_cnt", done_cnt, 1);
      chk("j33_words_end", words_left, 0);
      src_buf.delete();

      // zero-length job
      clr_counts();
      pulse_start(0);
      chk("j0_error", error, 1);
      chk("j0_busy", busy, 0);
      tick();
      chk("j0_error_one_cycle", error, 0);
      chk("j0_irq_cnt", irq_cnt, 0);
      chk("j0_err_cnt", err_cnt, 1);

      // 256 bits with FIFO full after 4 writes for 10 cycles
      clr_counts();
      load_words(8, 8);
      pulse_start(256);
      chk("j256_words_left", words_left, 8);
      n = 0;
      while (wr_cnt - wr0 < 4 && n < 100) begin tick(); n++; end
      fifo_full = 1'b1;
      repeat (10) begin
         tick();
         chk("full_src_ready", src_ready, 0);
      end
      chk("full_no_writes", wr_cnt - wr0, 4);
      chk("full_words_left", words_left, 4);
      fifo_full = 1'b0;
      wait_idle("j256", 100);
      chk("j256_writes", wr_cnt - wr0, 8);
      chk("j256_done_cnt", done_cnt, 1);
      chk("j256_exp_left", exp_q.size(), 0);

      // abort on 2nd write of a 5-word job
      clr_counts();
      load_words(5, 5);
      pulse_start(160);
      n = 0;
      while (wr_cnt - wr0 < 1 && n < 100) begin tick(); n++; end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_tx_irq", tx_irq, 1);
      chk("abort_busy", busy, 0);
      chk("abort_words_left", words_left, 0);
      chk("abort_src_ready", src_ready, 0);
      chk("abort_writes", wr_cnt - wr0, 2);
      tick();
      chk("abort_irq_one_cycle", tx_irq, 0);
      chk("abort_done_cnt", done_cnt, 0);
      chk("abort_exp_left", exp_q.size(), 3);
      exp_q.delete();
      src_buf.delete();
      tick();

      // normal job after abort
      clr_counts();
      load_words(2, 2);
      pulse_start(64);
      wait_idle("post_abort", 100);
      chk("post_abort_writes", wr_cnt - wr0, 2);
      chk("post_abort_done_cnt", done_cnt, 1);
      chk("post_abort_irq_cnt", irq_cnt, 1);

      // drain timeout with FIFO never empty
      clr_counts();
      fifo_empty = 1'b0;
      load_words(1, 1);
      pulse_start(32);
      n = 0; dcyc = 0;
      while (n < 100) begin
         tick();
         n++;
         if (error) break;
         if (busy && (wr_cnt - wr0) == 1) dcyc++;
      end
      chk("tmo_error", error, 1);
      chk("tmo_drain_cycles", dcyc, 16);
      chk("tmo_tx_irq", tx_irq, 1);
      chk("tmo_busy", busy, 0);
      chk("tmo_done_cnt", done_cnt, 0);
      fifo_empty = 1'b1;
      repeat (3) tick();
      chk("tmo_irq_cnt", irq_cnt, 2);

      // start during LOAD ignored
      clr_counts();
      fifo_full = 1'b1;
      load_words(4, 4);
      pulse_start(128);
      tick();
      chk("busy_start_words_before", words_left, 4);
      pulse_start(32);
      chk("busy_start_words_after", words_left, 4);
      tick();
      chk("busy_start_err_cnt", err_cnt, 0);
      chk("busy_start_irq_cnt", irq_cnt, 1);
      fifo_full = 1'b0;
      wait_idle("busy_start", 100);
      chk("busy_start_writes", wr_cnt - wr0, 4);

      // start + abort together in IDLE
      clr_counts();
      start = 1'b1; abort = 1'b1; data_size = 17'd64;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("idle_abort_busy", busy, 0);
      chk("idle_abort_words", words_left, 0);
      tick();
      chk("idle_abort_irq_cnt", irq_cnt, 0);
      chk("idle_abort_err_cnt", err_cnt, 0);

      // maximum length clamps to 4095 words, then reset mid-job
      fifo_full = 1'b1;
      pulse_start(131071);
      chk("clamp_words", words_left, 12'd4095);
      tick();
      RST = 1'b1;
      tick();
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_words", words_left, 0);
      chk("rst_mid_tx_irq", tx_irq, 0);
      RST = 1'b0;
      fifo_full = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
